// File: rtl/pipearch_reorder_pkg.sv
// Shared pipearch types: CCI-P read-response view, reorder FSM states,
// prefetch window defaults and the line-index helper.
package pipearch_common;
   localparam int PREFETCH_SIZE      = 64;
   localparam int LOG2_PREFETCH_SIZE = $clog2(PREFETCH_SIZE);
   localparam int LINE_BITS          = 512;

   typedef enum logic [1:0] {
      REORDER_IDLE = 2'd0,
      REORDER_RUN  = 2'd1,
      REORDER_DONE = 2'd2
   } t_reorderstate;

   typedef struct packed {
      logic [1:0]  cl_num;
      logic [15:0] mdata;
   } t_ccip_c0_RspMemHdr;

   typedef struct packed {
      logic                 rspValid;
      t_ccip_c0_RspMemHdr   hdr;
      logic [LINE_BITS-1:0] data;
   } t_if_ccip_c0_Rx;

   // mdata carries the burst base line, cl_num the offset inside the burst
   function automatic logic [31:0] line_index(input logic [15:0] mdata,
                                              input logic [1:0]  cl_num);
      return {16'b0, mdata} + {30'b0, cl_num};
   endfunction
endpackage

// File: rtl/pipearch_reorder_if.sv
// In-order line stream from the reorder stage to the compute pipeline
// (valid/ready handshake, payload plus line index).
interface pipearch_reorder_if;
   import pipearch_common::*;

   logic                 valid;
   logic                 ready;
   logic [LINE_BITS-1:0] data;
   logic [31:0]          index;

   modport master (output valid, data, index, input ready);
   modport slave  (input valid, data, index, output ready);
endinterface

// File: rtl/pipearch_reorder_ram.sv
// Simple dual-port line store: one write port, one read port with a
// registered (1-cycle) read.
module pipearch_reorder_ram #(
   parameter int LOG2_DEPTH = 6,
   parameter int WIDTH      = 512
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [LOG2_DEPTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [LOG2_DEPTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);
   logic [WIDTH-1:0] mem [2**LOG2_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/pipearch_reorder.sv
// Reorders prefetch read responses into line-index order through a BRAM window.
// Optional protocol checks are built with PIPEARCH_REORDER_CHECK_EN.
//
//   state | meaning
//   IDLE  | waiting for op_start
//   RUN   | parking responses and releasing lines in index order
//   DONE  | op_done pulse, then back to IDLE
module pipearch_reorder
   import pipearch_common::*;
#(
   parameter int LOG2_DEPTH = LOG2_PREFETCH_SIZE
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      op_start,
   input  logic [31:0]               length,
   output logic                      op_done,
   input  t_if_ccip_c0_Rx            in_rx,
   pipearch_reorder_if.master        out,
   output logic [31:0]               head,
   output logic                      error
);
   localparam int DEPTH = 2**LOG2_DEPTH;

   t_reorderstate        state;
   logic [31:0]          len_q;
   logic [DEPTH-1:0]     valid_bits;
   logic                 running;
   logic                 start_op;

   assign running  = (state == REORDER_RUN);
   assign start_op = (state == REORDER_IDLE) && op_start;

   logic                 rx_vld_q;
   logic [31:0]          rx_index_q;
   logic [LINE_BITS-1:0] rx_data_q;

   always_ff @(posedge clk) begin
      if (reset) rx_vld_q <= 1'b0;
      else       rx_vld_q <= in_rx.rspValid && running;
   end

   always_ff @(posedge clk) begin
      rx_index_q <= line_index(in_rx.hdr.mdata, in_rx.hdr.cl_num);
      rx_data_q  <= in_rx.data;
   end

   logic [LOG2_DEPTH-1:0] wr_slot;
   logic                  wr_en;
   assign wr_slot = rx_index_q[LOG2_DEPTH-1:0];

`ifdef PIPEARCH_REORDER_CHECK_EN
   logic [15:0] wr_dist;
   logic        wr_bad;
   logic        wr_err;
   // window distance wraps at 16 bits, matching the mdata tag width
   assign wr_dist = rx_index_q[15:0] - head[15:0];
   assign wr_bad  = valid_bits[wr_slot] || (wr_dist >= 16'(DEPTH)) || (rx_index_q >= len_q);
   assign wr_en   = rx_vld_q && running && !wr_bad;
   assign wr_err  = rx_vld_q && running && wr_bad;

   always_ff @(posedge clk) begin
      if (reset) error <= 1'b0;
      else begin
         if (start_op) error <= 1'b0;
         if (wr_err || (in_rx.rspValid && !running)) error <= 1'b1;
      end
   end
`else
   logic unused_index_bits;
   assign unused_index_bits = ^rx_index_q[31:LOG2_DEPTH];
   assign wr_en = rx_vld_q && running;
   assign error = 1'b0;
`endif

   logic [LOG2_DEPTH-1:0] head_slot;
   logic [1:0]            occ;
   logic                  rd_pend;
   logic                  rd_en;
   logic [31:0]           rd_index_q;
   logic [LINE_BITS-1:0]  ram_rdata;

   assign head_slot = head[LOG2_DEPTH-1:0];
   // never let more lines leave the window than the output FIFO can hold
   assign rd_en = running && valid_bits[head_slot] && (head < len_q)
                  && ((occ + {1'b0, rd_pend}) < 2'd2);

   always_ff @(posedge clk) begin
      if (reset || start_op) valid_bits <= '0;
      else begin
         if (rd_en) valid_bits[head_slot] <= 1'b0;
         if (wr_en) valid_bits[wr_slot]   <= 1'b1;
      end
   end

   pipearch_reorder_ram #(
      .LOG2_DEPTH (LOG2_DEPTH),
      .WIDTH      (LINE_BITS)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_slot),
      .wr_data (rx_data_q),
      .rd_en   (rd_en),
      .rd_addr (head_slot),
      .rd_data (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend    <= 1'b0;
         rd_index_q <= '0;
      end else begin
         rd_pend <= rd_en;
         if (rd_en) rd_index_q <= head;
      end
   end

   // 2-entry output FIFO; an empty FIFO forwards the RAM read directly
   logic [LINE_BITS-1:0] fifo_data  [2];
   logic [31:0]          fifo_index [2];
   logic                 wptr;
   logic                 rptr;
   logic                 bypass;
   logic                 pop;
   logic                 push;
   logic                 fifo_pop;

   assign bypass    = (occ == 2'd0) && rd_pend;
   assign out.valid = (occ != 2'd0) || rd_pend;
   assign out.data  = bypass ? ram_rdata  : fifo_data[rptr];
   assign out.index = bypass ? rd_index_q : fifo_index[rptr];
   assign pop       = out.valid && out.ready;
   assign push      = rd_pend && !(bypass && pop);
   assign fifo_pop  = pop && (occ != 2'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         occ  <= 2'd0;
         wptr <= 1'b0;
         rptr <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_data[i]  <= '0;
            fifo_index[i] <= '0;
         end
      end else begin
         if (push) begin
            fifo_data[wptr]  <= ram_rdata;
            fifo_index[wptr] <= rd_index_q;
            wptr             <= ~wptr;
         end
         if (fifo_pop) rptr <= ~rptr;
         occ <= occ + {1'b0, push} - {1'b0, fifo_pop};
      end
   end

   logic [1:0] stage_next;
   assign stage_next = occ + {1'b0, rd_pend} - {1'b0, pop};

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= REORDER_IDLE;
         len_q   <= '0;
         head    <= '0;
         op_done <= 1'b0;
      end else begin
         op_done <= 1'b0;
         case (state)
            REORDER_IDLE: begin
               if (op_start) begin
                  len_q <= length;
                  head  <= '0;
                  state <= REORDER_RUN;
               end
            end
            REORDER_RUN: begin
               if (rd_en) head <= head + 32'd1;
               if ((head == len_q) && (stage_next == 2'd0)) begin
                  state   <= REORDER_DONE;
                  op_done <= 1'b1;
               end
            end
            REORDER_DONE: state <= REORDER_IDLE;
            default:      state <= REORDER_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pipearch_reorder.sv
// Randomized self-checking bench for pipearch_reorder against an index-ordered
// scoreboard; expectations on the error flag follow PIPEARCH_REORDER_CHECK_EN.
module tb_pipearch_reorder;
   import pipearch_common::*;

   localparam int DEPTH = 2**LOG2_PREFETCH_SIZE;

   logic           clk;
   logic           reset;
   logic           op_start;
   logic [31:0]    length;
   logic           op_done;
   t_if_ccip_c0_Rx in_rx;
   logic [31:0]    head;
   logic           error;

   pipearch_reorder_if out_if ();

   pipearch_reorder dut (
      .clk      (clk),
      .reset    (reset),
      .op_start (op_start),
      .length   (length),
      .op_done  (op_done),
      .in_rx    (in_rx),
      .out      (out_if),
      .head     (head),
      .error    (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors     = 0;
   int miscompares = 0;

   // ready pattern: 0 held high, 1 toggling, 2 random, 3 held low
   int ready_mode = 0;
   initial out_if.ready = 1'b1;
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_if.ready = 1'b1;
         1:       out_if.ready = !out_if.ready;
         2:       out_if.ready = ($urandom_range(0, 3) != 0);
         default: out_if.ready = 1'b0;
      endcase
   end

   // monitor: handshakes, op_done pulses, stall stability, release lead
   int                   hs_idx  [$];
   logic [LINE_BITS-1:0] hs_data [$];
   int                   hs_cyc  [$];
   int                   done_cyc[$];
   int                   stab_viol  = 0;
   int                   acc_cnt    = 0;
   int                   max_excess = 0;
   logic                 prev_stall = 1'b0;
   logic [LINE_BITS-1:0] prev_data;
   logic [31:0]          prev_index;

   always @(negedge clk) begin
      if (op_start) begin
         acc_cnt    = 0;
         max_excess = 0;
      end else if (int'(head) - acc_cnt > max_excess) begin
         max_excess = int'(head) - acc_cnt;
      end
      if (prev_stall && (!out_if.valid || out_if.data !== prev_data || out_if.index !== prev_index))
         stab_viol++;
      prev_stall = out_if.valid && !out_if.ready && !reset;
      prev_data  = out_if.data;
      prev_index = out_if.index;
      if (out_if.valid && out_if.ready && !reset) begin
         hs_idx.push_back(int'(out_if.index));
         hs_data.push_back(out_if.data);
         hs_cyc.push_back(cyc);
         acc_cnt++;
      end
      if (op_done) done_cyc.push_back(cyc);
   end

   // reference model: line payload by index; release order is simply 0..len-1
   logic [LINE_BITS-1:0] model_mem [int];
   int hs_base, done_base, viol_base, start_cyc;

   function automatic logic [LINE_BITS-1:0] rand_line();
      logic [LINE_BITS-1:0] v;
      for (int i = 0; i < LINE_BITS/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic send_line(input int idx, input int cl, input logic [LINE_BITS-1:0] d);
      in_rx.rspValid   = 1'b1;
      in_rx.hdr.mdata  = 16'(idx - cl);
      in_rx.hdr.cl_num = 2'(cl);
      in_rx.data       = d;
      model_mem[idx]   = d;
      @(posedge clk); #1;
      in_rx.rspValid   = 1'b0;
   endtask

   task automatic op_begin(input int len);
      model_mem.delete();
      hs_base   = hs_idx.size();
      done_base = done_cyc.size();
      viol_base = stab_viol;
      start_cyc = cyc;
      length    = 32'(len);
      op_start  = 1'b1;
      @(posedge clk); #1;
      op_start  = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int k = 0; k < budget; k++) begin
         if (done_cyc.size() > done_base) break;
         @(posedge clk); #1;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      vectors++; if (out_if.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_if.valid); end
      vectors++; if (out_if.data !== '0) begin miscompares++; $display("FAIL reset_data got %h want 0", out_if.data); end
      vectors++; if (out_if.index !== 32'd0) begin miscompares++; $display("FAIL reset_index got %0d want 0", out_if.index); end
      vectors++; if (op_done !== 1'b0) begin miscompares++; $display("FAIL reset_op_done got %b want 0", op_done); end
      vectors++; if (head !== 32'd0) begin miscompares++; $display("FAIL reset_head got %0d want 0", head); end
      vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error got %b want 0", error); end
   endtask

   task automatic test_in_order();
      int t0;
      ready_mode = 0;
      op_begin(4);
      t0 = cyc;
      for (int i = 0; i < 4; i++) send_line(i, 0, rand_line());
      wait_done(40);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (hs_idx.size() <= hs_base + i) begin
            miscompares++; $display("FAIL in_order line %0d not emitted, want index %0d", i, i);
         end else if (hs_idx[hs_base+i] !== i || hs_data[hs_base+i] !== model_mem[i] || hs_cyc[hs_base+i] !== t0 + 3 + i) begin
            miscompares++;
            $display("FAIL in_order line %0d got index %0d cycle %0d, want index %0d cycle %0d (data match %b)",
                     i, hs_idx[hs_base+i], hs_cyc[hs_base+i], i, t0 + 3 + i, hs_data[hs_base+i] === model_mem[i]);
         end
      end
      vectors++;
      if (done_cyc.size() != done_base + 1 || hs_idx.size() < hs_base + 4) begin
         miscompares++; $display("FAIL in_order_done got %0d pulses, want 1", done_cyc.size() - done_base);
      end else if (done_cyc[done_base] !== hs_cyc[hs_base+3] + 1) begin
         miscompares++; $display("FAIL in_order_done got cycle %0d want %0d", done_cyc[done_base], hs_cyc[hs_base+3] + 1);
      end
      vectors++; if (head !== 32'd4) begin miscompares++; $display("FAIL in_order_head got %0d want 4", head); end
      vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL in_order_error got %b want 0", error); end
   endtask

   task automatic test_reversed();
      int t0;
      ready_mode = 0;
      op_begin(4);
      t0 = cyc;
      for (int i = 3; i >= 0; i--) send_line(i, 0, rand_line());
      wait_done(40);
      vectors++;
      if (hs_idx.size() - hs_base != 4) begin
         miscompares++; $display("FAIL reversed_count got %0d want 4", hs_idx.size() - hs_base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (hs_idx[hs_base+i] !== i || hs_data[hs_base+i] !== model_mem[i] || hs_cyc[hs_base+i] !== t0 + 6 + i) begin
               miscompares++;
               $display("FAIL reversed line %0d got index %0d cycle %0d, want index %0d cycle %0d",
                        i, hs_idx[hs_base+i], hs_cyc[hs_base+i], i, t0 + 6 + i);
            end
         end
      end
   endtask

   task automatic test_multi_line();
      int cls [4] = '{3, 1, 0, 2};
      ready_mode = 0;
      op_begin(8);
      for (int i = 0; i < 4; i++) send_line(i, 0, rand_line());
      for (int k = 0; k < 4; k++) send_line(4 + cls[k], cls[k], rand_line());
      wait_done(60);
      vectors++;
      if (hs_idx.size() - hs_base != 8) begin
         miscompares++; $display("FAIL multi_count got %0d want 8", hs_idx.size() - hs_base);
      end else begin
         for (int i = 0; i < 8; i++) begin
            vectors++;
            if (hs_idx[hs_base+i] !== i || hs_data[hs_base+i] !== model_mem[i]) begin
               miscompares++; $display("FAIL multi line %0d got index %0d want %0d", i, hs_idx[hs_base+i], i);
            end
         end
      end
      vectors++; if (head !== 32'd8) begin miscompares++; $display("FAIL multi_head got %0d want 8", head); end
   endtask

   task automatic test_backpressure();
      ready_mode = 1;
      op_begin(8);
      for (int i = 0; i < 8; i++) send_line(i, 0, rand_line());
      wait_done(100);
      vectors++;
      if (hs_idx.size() - hs_base != 8) begin
         miscompares++; $display("FAIL bp_count got %0d want 8", hs_idx.size() - hs_base);
      end else begin
         for (int i = 0; i < 8; i++) begin
            vectors++;
            if (hs_idx[hs_base+i] !== i || hs_data[hs_base+i] !== model_mem[i]) begin
               miscompares++; $display("FAIL bp line %0d got index %0d want %0d", i, hs_idx[hs_base+i], i);
            end
         end
         vectors++;
         if (done_cyc.size() != done_base + 1 || done_cyc[done_base] !== hs_cyc[hs_base+7] + 1) begin
            miscompares++; $display("FAIL bp_done got %0d pulses, want 1 pulse at cycle %0d", done_cyc.size() - done_base, hs_cyc[hs_base+7] + 1);
         end
      end
      vectors++; if (stab_viol != viol_base) begin miscompares++; $display("FAIL bp_stable got %0d changes while stalled want 0", stab_viol - viol_base); end
      vectors++; if (max_excess > 2) begin miscompares++; $display("FAIL bp_head_lead got %0d want <= 2", max_excess); end
      vectors++; if (head !== 32'd8) begin miscompares++; $display("FAIL bp_head got %0d want 8", head); end
      ready_mode = 0;
   endtask

   task automatic test_zero_length();
      ready_mode = 0;
      op_begin(0);
      wait_done(10);
      vectors++;
      if (done_cyc.size() != done_base + 1) begin
         miscompares++; $display("FAIL zero_done got %0d pulses want 1", done_cyc.size() - done_base);
      end else if (done_cyc[done_base] !== start_cyc + 2) begin
         miscompares++; $display("FAIL zero_done got cycle %0d want %0d", done_cyc[done_base], start_cyc + 2);
      end
      vectors++; if (hs_idx.size() != hs_base) begin miscompares++; $display("FAIL zero_lines got %0d want 0", hs_idx.size() - hs_base); end
   endtask

   task automatic test_duplicate();
      logic [LINE_BITS-1:0] first2;
      logic                 want_err;
      ready_mode = 0;
      op_begin(4);
      send_line(3, 0, rand_line());
      first2 = rand_line();
      send_line(2, 0, first2);
      send_line(2, 0, rand_line());
`ifdef PIPEARCH_REORDER_CHECK_EN
      model_mem[2] = first2;
      want_err = 1'b1;
`else
      want_err = 1'b0;
`endif
      send_line(0, 0, rand_line());
      send_line(1, 0, rand_line());
      wait_done(40);
      vectors++;
      if (hs_idx.size() - hs_base != 4) begin
         miscompares++; $display("FAIL dup_count got %0d want 4", hs_idx.size() - hs_base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (hs_idx[hs_base+i] !== i || hs_data[hs_base+i] !== model_mem[i]) begin
               miscompares++; $display("FAIL dup line %0d got index %0d want %0d (data match %b)",
                                       i, hs_idx[hs_base+i], i, hs_data[hs_base+i] === model_mem[i]);
            end
         end
      end
      vectors++; if (error !== want_err) begin miscompares++; $display("FAIL dup_error got %b want %b", error, want_err); end
   endtask

   task automatic test_random();
      int len, j, tmp, idx, cl;
      int perm [$];
      for (int it = 0; it < 4; it++) begin
         len = $urandom_range(1, DEPTH);
         ready_mode = 2;
         perm.delete();
         for (int i = 0; i < len; i++) perm.push_back(i);
         for (int i = len - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
         end
         op_begin(len);
         for (int k = 0; k < len; k++) begin
            idx = perm[k];
            cl  = $urandom_range(0, (idx < 3) ? idx : 3);
            send_line(idx, cl, rand_line());
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         end
         wait_done(len * 8 + 50);
         vectors++;
         if (hs_idx.size() - hs_base != len) begin
            miscompares++; $display("FAIL random_count op %0d got %0d want %0d", it, hs_idx.size() - hs_base, len);
         end else begin
            for (int i = 0; i < len; i++) begin
               vectors++;
               if (hs_idx[hs_base+i] !== i || hs_data[hs_base+i] !== model_mem[i]) begin
                  miscompares++; $display("FAIL random op %0d line %0d got index %0d want %0d", it, i, hs_idx[hs_base+i], i);
               end
            end
         end
         vectors++; if (done_cyc.size() != done_base + 1) begin miscompares++; $display("FAIL random_done op %0d got %0d pulses want 1", it, done_cyc.size() - done_base); end
         vectors++; if (stab_viol != viol_base) begin miscompares++; $display("FAIL random_stable op %0d got %0d changes want 0", it, stab_viol - viol_base); end
         vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL random_error op %0d got %b want 0", it, error); end
      end
      ready_mode = 0;
   endtask

   task automatic test_reset_mid();
      int dbase;
      ready_mode = 0;
      op_begin(6);
      send_line(0, 0, rand_line());
      send_line(1, 0, rand_line());
      for (int k = 0; k < 30 && (hs_idx.size() - hs_base) < 2; k++) begin @(posedge clk); #1; end
      send_line(3, 0, rand_line());
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      vectors++; if (hs_idx.size() - hs_base != 2) begin miscompares++; $display("FAIL mid_emitted got %0d want 2", hs_idx.size() - hs_base); end
      vectors++; if (out_if.valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got %b want 0", out_if.valid); end
      vectors++; if (head !== 32'd0) begin miscompares++; $display("FAIL mid_head got %0d want 0", head); end
      dbase = done_cyc.size();
      repeat (6) @(posedge clk);
      #1;
      vectors++; if (done_cyc.size() != dbase || out_if.valid !== 1'b0) begin miscompares++; $display("FAIL mid_quiet got %0d op_done pulses valid %b want 0 and 0", done_cyc.size() - dbase, out_if.valid); end
      op_begin(2);
      send_line(0, 0, rand_line());
      send_line(1, 0, rand_line());
      wait_done(30);
      vectors++;
      if (hs_idx.size() - hs_base != 2) begin
         miscompares++; $display("FAIL mid_restart_count got %0d want 2", hs_idx.size() - hs_base);
      end else begin
         for (int i = 0; i < 2; i++) begin
            vectors++;
            if (hs_idx[hs_base+i] !== i || hs_data[hs_base+i] !== model_mem[i]) begin
               miscompares++; $display("FAIL mid_restart line %0d got index %0d want %0d", i, hs_idx[hs_base+i], i);
            end
         end
      end
      vectors++; if (done_cyc.size() != done_base + 1) begin miscompares++; $display("FAIL mid_restart_done got %0d pulses want 1", done_cyc.size() - done_base); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      op_start = 1'b0;
      length   = '0;
      in_rx    = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_in_order();
      test_reversed();
      test_multi_line();
      test_backpressure();
      test_zero_length();
      test_duplicate();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pipearch_reorder.md
# pipearch_reorder

Restores line order for read responses leaving the prefetch stage. Responses arrive in CCI-P completion order, tagged with mdata (base line index) and cl_num (offset within a multi-line burst). The block parks each line in a BRAM slot keyed by its index and releases lines to the compute pipeline strictly in index order, with valid/ready handshake. It exports its release head so the requester can bound in-flight lines to the window depth.

## Interface
- LOG2_DEPTH, default LOG2_PREFETCH_SIZE: log2 of the reorder window, in lines; DEPTH = 2**LOG2_DEPTH.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- op_start  in  1  one-cycle pulse that starts an operation.
- length  in  32  lines in the operation; sampled on op_start.
- op_done  out  1  one-cycle pulse after the last line is accepted.
- in_rx  in  t_if_ccip_c0_Rx  response stream from prefetch; only rspValid, hdr.mdata, hdr.cl_num and data are used.
- out_valid  out  1  out_data/out_index hold a line.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  512  line payload.
- out_index  out  32  line index, 0..length-1.
- head  out  32  lines released so far. Requester invariant: requested - head <= DEPTH.
- error  out  1  sticky protocol-violation flag.

## Operation
- Line index = {16'b0, mdata} + cl_num. Slot = index[LOG2_DEPTH-1:0].
- Per-slot valid bits are held in flops, DEPTH bits.
- States: IDLE, RUN, DONE.
  - IDLE: op_start latches length, clears head and all valid bits, and moves to RUN. The transition is unconditional on length.
  - RUN: accepts responses and releases lines. When head == length and the output stage is empty, move to DONE. A length of 0 therefore reaches DONE on the cycle after entering RUN.
  - DONE: pulse op_done, return to IDLE.
- op_start is ignored outside IDLE.
- Responses with rspValid outside RUN are dropped.
- Write path: the input is registered. On the next cycle the data is written to slot and valid[slot] is set.
- Release path: a read is issued when valid[head slot] && head < length && (output occupancy + pending reads) < 2.
  - The read clears valid[head slot] and increments head.
  - Data returns one cycle later into a 2-entry output FIFO.
- Setting one valid bit and clearing another in the same cycle both take effect.
- A write to the head slot on cycle N is eligible for a read on cycle N+1, never on the same cycle.
- Index arithmetic is modulo 2**16 against head[15:0].
- Reset mid-operation: state goes to IDLE, valid bits clear, the output FIFO empties, and head returns to 0. In-flight responses after reset are dropped.

## Timing
- Reset values: out_valid 0, out_data 0, out_index 0, op_done 0, head 0, error 0.
- Latency from the rspValid cycle of an in-order line to out_valid is 3 cycles: register, write, read.
- Sustained throughput is 1 line/cycle with out_ready held high and in-order arrival.
- out_valid, out_data and out_index are stable while out_valid && !out_ready.
- Backpressure from out_ready never drops input. The window invariant guarantees a free slot.
- op_done asserts exactly 1 cycle after the handshake of line length-1 (the DONE cycle). It asserts 2 cycles after op_start when length is 0.

## Configuration
- PIPEARCH_REORDER_CHECK_EN defined: error sets and stays set until reset or op_start in any of these cases:
  - a write targets a slot whose valid bit is already set (duplicate or window overrun);
  - index - head >= DEPTH;
  - index >= length;
  - rspValid arrives outside RUN.
  The offending line is dropped.
- PIPEARCH_REORDER_CHECK_EN undefined: error is tied to 0, no checks run, and such writes overwrite the slot.

## Structure
- Shared package (pipearch_common): the state typedef t_reorderstate, the PREFETCH_SIZE/LOG2_PREFETCH_SIZE defaults, and the index-extraction helper (mdata + cl_num).
- One sub-module, pipearch_reorder_ram: simple dual-port BRAM of DEPTH × 512 bits, one write port, one read port, 1-cycle registered read.
- The output FIFO and valid bits stay in the top level.

## Test plan
- In-order: length 4, mdata 0..3 on consecutive cycles, out_ready=1. Expect out_index 0,1,2,3 on consecutive cycles, the first 3 cycles after the first rspValid. op_done on the cycle after index 3.
- Reversed: length 4, mdata 3,2,1,0. Expect no out_valid before index 0 arrives, then 0..3 back-to-back.
- Multi-line: one burst with mdata=4, cl_num 3,1,0,2 after lines 0..3. Expect indices 4..7 in order and head=8.
- Backpressure: length 8 in order, out_ready toggling 1/0. Expect every index exactly once, data stable while stalled, head never exceeding accepted+2.
- Check build: duplicate mdata=2 while slot 2 is valid. Expect error=1, the original data for index 2 emitted, the duplicate dropped. Without the macro, expect error=0.
- Reset at mid-operation (2 of 6 lines emitted). Expect out_valid=0, head=0, no op_done. A new op_start with length 2 completes normally.
